inm_gen_pipe: RTL
=================

// Module: inm_gen_pipe
// PURPOSE
//  Registered, XLEN-parametrised successor of the combinational immediate generator.
//  Sits between instruction fetch and the ID/EX register.
//  Decodes the immediate plus a format tag and illegal flag, and precomputes PC-relative targets.
//  Uses a valid/ready handshake with a 2-entry skid buffer, so upstream never sees a
//  combinational path from out_ready.
// PARAMETERS
//  XLEN    32  datapath width, 32 or 64; immediates sign-extend to XLEN
//  EN_CSR  1   1: SYSTEM CSR*I instructions (funct3[2]=1) give zimm=inst[19:15] zero-extended; 0: flagged illegal
// PORTS
//  clk         in   1     system clock, rising edge
//  rst_n       in   1     asynchronous reset, active low
//  flush       in   1     synchronous flush: discard all buffered entries
//  in_valid    in   1     in_inst/in_pc valid
//  in_ready    out  1     block can accept an entry this cycle
//  in_inst     in   32    instruction word
//  in_pc       in   XLEN  PC of in_inst
//  out_valid   out  1     output entry valid
//  out_ready   in   1     downstream accepts the entry
//  out_inm     out  XLEN  decoded immediate
//  out_fmt     out  3     fmt_e: NONE,I,S,B,U,J,CSR
//  out_target  out  XLEN  pc+inm for B/J/AUIPC; otherwise pc+4
//  out_pc      out  XLEN  PC passed through
//  out_illegal out  1     opcode not in supported set
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - out_valid=0, in_ready=1.
//   - out_inm, out_target and out_pc reset to 0; out_fmt=NONE; out_illegal=0.
//   - Both skid entries are emptied.
//  Handshake:
//   - Transfer occurs when valid&&ready on either side.
//   - Latency is 1 cycle: an entry accepted at edge N is visible on the outputs after edge N.
//   - in_ready is registered: in_ready = (count<2).
//   - While out_valid=1 and out_ready=0, the outputs hold stable.
//  Occupancy FSM, count in {EMPTY,ONE,TWO}:
//   - EMPTY --in xfer--> ONE.
//   - ONE: in xfer without out xfer -> TWO; out xfer without in xfer -> EMPTY;
//     both -> stays ONE (new entry becomes head).
//   - TWO: out xfer -> ONE (skid entry promoted to head). in_ready=0, so no in xfer.
//  Flush has priority over everything:
//   - Next state is EMPTY.
//   - An input accepted in the same cycle is dropped.
//   - out_valid=0 on the next cycle.
//  Decode, per opcode:
//   - LOAD/OP-IMM/JALR -> I, sext(inst[31:20]).
//   - STORE -> S, sext(inst[31:25],inst[11:7]).
//   - BRANCH -> B, sext(inst[31],inst[7],inst[30:25],inst[11:8],0).
//   - LUI/AUIPC -> U, sext({inst[31:12],12'b0}); bit 31 is replicated when XLEN=64.
//   - JAL -> J, sext(inst[31],inst[19:12],inst[20],inst[30:21],0).
//   - OP -> NONE, imm 0.
//   - SYSTEM with funct3[2]=1 and EN_CSR=1 -> CSR, zero-extended zimm.
//   - SYSTEM otherwise -> NONE, imm 0.
//   - Any other opcode -> NONE, imm 0, out_illegal=1. The illegal entry is still passed
//     downstream like any other.
//  Arithmetic:
//   - out_target is an XLEN-bit modulo-2^XLEN add; the carry is discarded
//     (e.g. pc=FFFF_FFFC + 8 -> 0000_0004).
//  Reset mid-operation: any buffered entries are lost and the block restarts from EMPTY.
// STRUCTURE
//  inm_pkg holds:
//   - opcode localparams: LOAD, OP_IMM, STORE, BRANCH, LUI, AUIPC, JAL, JALR, OP, SYSTEM.
//   - typedef enum logic [2:0] fmt_e.
//   - typedef struct entry_t {inm, target, pc, fmt, illegal}, parametrised through XLEN
//     in the module.
//  Sub-module inm_decode_comb #(XLEN,EN_CSR): purely combinational, inst+pc -> entry_t.
//  Top level: inm_decode_comb, head and skid entry_t registers, and the count FSM.
// TESTING
//  T1 reset: assert rst_n=0 mid-stream with 2 entries held.
//     -> out_valid=0 and in_ready=1 immediately (asynchronous); out_fmt=NONE.
//  T2 decode: ADDI x1,x0,-1 (FFF00093), XLEN=32.
//     -> out_inm=FFFF_FFFF, fmt=I, one cycle after acceptance.
//  T3 branch: BEQ with offset -4 (FE000EE3) at pc=0000_0100.
//     -> out_inm=FFFF_FFFC, out_target=0000_00FC.
//  T4 back-pressure: out_ready=0 while 3 instructions are offered back-to-back.
//     -> in_ready drops after 2 are accepted; outputs hold.
//     -> release out_ready: 2 entries delivered in order, no loss or duplication.
//  T5 flush while count=TWO with in_valid=1.
//     -> next cycle out_valid=0, count EMPTY; the offered instruction never appears.
//  T6 XLEN=64: LUI x1,0x80000 (800000B7).
//     -> out_inm=FFFF_FFFF_8000_0000.
//  T6 XLEN=64: CSRRWI (EN_CSR=1) with rs1=5'h1F.
//     -> out_inm=1F, fmt=CSR.
//  T6 XLEN=64: opcode 7'b1111111.
//     -> out_illegal=1.

Source files
------------

// File: rtl/inm_gen_pipe_pkg.sv
// Shared opcodes, immediate format tag and entry sizing for the immediate-generator pipe.
package inm_pkg;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        FmtNone = 3'd0,
        FmtI    = 3'd1,
        FmtS    = 3'd2,
        FmtB    = 3'd3,
        FmtU    = 3'd4,
        FmtJ    = 3'd5,
        FmtCsr  = 3'd6
    } fmt_e;

    // entry_t is declared per module (it depends on XLEN); this is its packed width:
    // inm + target + pc + fmt + illegal.
    function automatic int unsigned entry_w(input int unsigned xlen);
        return 3 * xlen + 3 + 1;
    endfunction

endpackage

// File: rtl/inm_gen_pipe_if.sv
// Fetch-side and ID/EX-side handshake bundle of the immediate-generator pipe.
interface inm_gen_pipe_if #(
    parameter int unsigned XLEN = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_inst;
    logic [XLEN-1:0]     in_pc;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_inm;
    inm_pkg::fmt_e       out_fmt;
    logic [XLEN-1:0]     out_target;
    logic [XLEN-1:0]     out_pc;
    logic                out_illegal;

    // The pipe itself.
    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inm, out_fmt, out_target, out_pc, out_illegal
    );

    // Whoever feeds and drains the pipe.
    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inm, out_fmt, out_target, out_pc, out_illegal
    );
endinterface

// File: rtl/inm_gen_pipe_decode.sv
// Combinational decode of one instruction word into a complete pipe entry.
module inm_decode_comb
    import inm_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter bit          EN_CSR = 1'b1
) (
    input  logic [31:0]              inst,
    input  logic [XLEN-1:0]          pc,
    output logic [entry_w(XLEN)-1:0] entry
);

    typedef struct packed {
        logic [XLEN-1:0] inm;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        fmt_e            fmt;
        logic            illegal;
    } entry_t;

    entry_t e;
    logic   pc_rel;

    // Signed raw immediates; the XLEN size casts below sign-extend them.
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;

    assign imm_i = inst[31:20];
    assign imm_s = {inst[31:25], inst[11:7]};
    assign imm_b = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Select immediate and format by opcode, then form the pc-relative or sequential target.
    always_comb begin
        e      = '0;
        pc_rel = 1'b0;
        case (inst[6:0])
            LOAD, OP_IMM, JALR: begin e.fmt = FmtI; e.inm = XLEN'(imm_i); end
            STORE:              begin e.fmt = FmtS; e.inm = XLEN'(imm_s); end
            BRANCH:             begin e.fmt = FmtB; e.inm = XLEN'(imm_b); pc_rel = 1'b1; end
            LUI:                begin e.fmt = FmtU; e.inm = XLEN'(imm_u); end
            AUIPC:              begin e.fmt = FmtU; e.inm = XLEN'(imm_u); pc_rel = 1'b1; end
            JAL:                begin e.fmt = FmtJ; e.inm = XLEN'(imm_j); pc_rel = 1'b1; end
            OP:                 e.fmt = FmtNone;
            SYSTEM: begin
                // funct3[2] marks the CSR*I group carrying a 5-bit zimm in the rs1 field.
                if (inst[14]) begin
                    if (EN_CSR) begin
                        e.fmt = FmtCsr;
                        e.inm = XLEN'(inst[19:15]);
                    end else begin
                        e.illegal = 1'b1;
                    end
                end
            end
            default:            e.illegal = 1'b1;
        endcase
        e.pc     = pc;
        e.target = pc + (pc_rel ? e.inm : XLEN'(4));
    end

    assign entry = e;

endmodule

// File: rtl/inm_gen_pipe.sv
// Registered immediate generator: decode feeding a 2-entry skid buffer with registered in_ready.
module inm_gen_pipe
    import inm_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter bit          EN_CSR = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    inm_gen_pipe_if.slave bus
);

    typedef struct packed {
        logic [XLEN-1:0] inm;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        fmt_e            fmt;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e                     state_q, state_d;
    entry_t                     head_q, head_d;
    entry_t                     skid_q, skid_d;
    logic                       in_ready_q;
    logic [entry_w(XLEN)-1:0]   dec_flat;
    entry_t                     dec;
    logic                       out_valid;
    logic                       in_xfer;
    logic                       out_xfer;

    inm_decode_comb #(
        .XLEN   (XLEN),
        .EN_CSR (EN_CSR)
    ) u_decode (
        .inst  (bus.in_inst),
        .pc    (bus.in_pc),
        .entry (dec_flat)
    );

    assign dec       = entry_t'(dec_flat);
    assign out_valid = (state_q != StEmpty);
    assign in_xfer   = bus.in_valid & in_ready_q;
    assign out_xfer  = out_valid & bus.out_ready;

    // Occupancy FSM: head is always the entry presented downstream, skid holds the second.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    state_d = StOne;
                    head_d  = dec;
                end
            end
            StOne: begin
                if (in_xfer && out_xfer) begin
                    head_d = dec;
                end else if (in_xfer) begin
                    state_d = StTwo;
                    skid_d  = dec;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                if (out_xfer) begin
                    state_d = StOne;
                    head_d  = skid_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush wins over any transfer; a same-cycle input is simply not kept.
        if (flush) begin
            state_d = StEmpty;
            head_d  = head_q;
            skid_d  = skid_q;
        end
    end

    // State, buffers and the registered in_ready derived from next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StEmpty;
            head_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != StTwo);
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid;
    assign bus.out_inm     = head_q.inm;
    assign bus.out_fmt     = head_q.fmt;
    assign bus.out_target  = head_q.target;
    assign bus.out_pc      = head_q.pc;
    assign bus.out_illegal = head_q.illegal;

endmodule
